im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_pkg.sv | 28 ++
 rtl/im_word_packer.sv | 66 ++++++
 rtl/im_loader.sv | 129 ++++++++++++
 tb/tb_im_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
`default_nettype none
// ============================================================================
// Module  : im_pkg
// Brief   : Shared loader state encoding, error codes and memory base address.
// Revision: 1.0
// ============================================================================
package im_pkg;

    typedef logic [3:0] err_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam err_t ERR_NONE = 4'd0;
    localparam err_t ERR_LEN  = 4'd1;
    localparam err_t ERR_SUM  = 4'd2;
    localparam err_t ERR_TMO  = 4'd3;

    // PC of instruction-memory word 0.
    localparam logic [15:0] IM_BASE_PC = 16'h3000;

endpackage
`default_nettype wire

// File: rtl/im_word_packer.sv
`default_nettype none
// ============================================================================
// Module  : im_word_packer
// Brief   : Packs bytes little-endian into 32-bit words and issues one-cycle writes.
// Revision: 1.0
// ============================================================================
module im_word_packer #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic              word_done,
    output logic [ADDR_W-1:0] word_idx,
    output logic [3:0]        im_wea,
    output logic [ADDR_W-1:0] im_addra,
    output logic [31:0]       im_dina
);

    logic [1:0]        r_lane;
    logic [23:0]       r_part;
    logic [ADDR_W-1:0] r_idx;
    logic [3:0]        r_wea;
    logic [ADDR_W-1:0] r_addra;
    logic [31:0]       r_dina;

    assign word_done = accept && (r_lane == 2'd3);
    assign word_idx  = r_idx;
    assign im_wea    = r_wea;
    assign im_addra  = r_addra;
    assign im_dina   = r_dina;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane  <= 2'd0;
            r_part  <= 24'd0;
            r_idx   <= '0;
            r_wea   <= 4'd0;
            r_addra <= '0;
            r_dina  <= 32'd0;
        end else begin
            r_wea <= 4'd0;
            if (clear) begin
                r_lane <= 2'd0;
                r_part <= 24'd0;
                r_idx  <= '0;
            end else if (accept) begin
                if (r_lane == 2'd3) begin
                    r_wea   <= 4'b1111;
                    r_addra <= r_idx;
                    r_dina  <= {byte_data, r_part};
                    r_idx   <= r_idx + ADDR_W'(1);
                    r_lane  <= 2'd0;
                end else begin
                    // Shifting in from the top leaves byte 0 in [7:0] after three bytes.
                    r_part <= {byte_data, r_part[23:8]};
                    r_lane <= r_lane + 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module  : im_loader
// Brief   : Byte-stream instruction-memory loader with length, checksum and timeout.
// Revision: 1.0
// ============================================================================
module im_loader
    import im_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 2048,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [3:0]        im_wea,
    output logic [ADDR_W-1:0] im_addra,
    output logic [31:0]       im_dina,
    output logic              cpu_hold,
    output logic              done,
    output logic [3:0]        error
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [7:0]        r_sum;
    logic [CNT_W-1:0]  r_cnt;
    err_t              r_err;

    logic              w_active;
    logic              w_accept;
    logic              w_clear;
    logic [15:0]       w_len;
    logic              w_word_done;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_last;

    assign w_active   = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CHECK);
    assign w_accept   = byte_valid && w_active;
    assign w_clear    = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERR));
    assign w_len      = {byte_data, r_len_lo};
    assign w_last     = w_word_done && (16'(w_word_idx) == (r_len - 16'd1));

    assign byte_ready = w_active;
    assign cpu_hold   = w_active || (r_state == S_ERR);
    assign done       = (r_state == S_DONE);
    assign error      = r_err;

    im_word_packer #(
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .accept    (w_accept && (r_state == S_DATA)),
        .byte_data (byte_data),
        .word_done (w_word_done),
        .word_idx  (w_word_idx),
        .im_wea    (im_wea),
        .im_addra  (im_addra),
        .im_dina   (im_dina)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_len_lo <= 8'd0;
            r_len    <= 16'd0;
            r_sum    <= 8'd0;
            r_cnt    <= '0;
            r_err    <= ERR_NONE;
        end else if (!w_active) begin
            if (start) begin
                r_state <= S_LEN_LO;
                r_err   <= ERR_NONE;
                r_sum   <= 8'd0;
                r_cnt   <= '0;
            end
        end else begin
            r_cnt <= w_accept ? '0 : r_cnt + CNT_W'(1);
            if (!w_accept && (r_cnt == c_tmo_last)) begin
                r_state <= S_ERR;
                r_err   <= ERR_TMO;
            end else if (w_accept) begin
                case (r_state)
                    S_LEN_LO: begin
                        r_len_lo <= byte_data;
                        r_state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        r_len <= w_len;
                        if ((w_len == 16'd0) || (w_len > 16'(MAX_WORDS))) begin
                            r_state <= S_ERR;
                            r_err   <= ERR_LEN;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_sum <= r_sum ^ byte_data;
                        // The final word's write issues on the first CHECK cycle,
                        // one edge before the checksum byte can be compared.
                        if (w_last) r_state <= S_CHECK;
                    end
                    default: begin
                        if (byte_data == r_sum) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= ERR_SUM;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_im_loader
// Brief   : Table-driven self-checking bench for im_loader.
// Revision: 1.0
// ============================================================================
module tb_im_loader;

    localparam int ADDR_W    = 11;
    localparam int MAX_WORDS = 2048;
    localparam int TIMEOUT   = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic [3:0]        im_wea;
    logic [ADDR_W-1:0] im_addra;
    logic [31:0]       im_dina;
    logic              cpu_hold;
    logic              done;
    logic [3:0]        error;

    im_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_wea     (im_wea),
        .im_addra   (im_addra),
        .im_dina    (im_dina),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          wr_total = 0;
    int          wr_odd = 0;
    logic [10:0] last_addr = '0;
    logic [31:0] last_data = '0;

    // Each write is a one-cycle pulse, so sampling at negedge sees it exactly once.
    always @(negedge clk) begin
        if (im_wea != 4'd0) begin
            wr_total  = wr_total + 1;
            last_addr = im_addra;
            last_data = im_dina;
            if (im_wea != 4'hF) wr_odd = wr_odd + 1;
        end
    end

    typedef struct {
        string            name;
        int               n;
        logic [0:11][7:0] b;
        int               wr;
        logic [10:0]      addr;
        logic [31:0]      data;
        logic             dn;
        logic [3:0]       err;
        logic             hold;
        logic             rdy;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit rst);
        int base;
        if (rst) do_reset();
        base = wr_total;
        go();
        for (int i = 0; i < v.n; i++) send(v.b[i]);
        tick(); tick();
        chk({v.name, ".writes"}, 32'(wr_total - base), 32'(v.wr));
        if (v.wr > 0) begin
            chk({v.name, ".addra"}, 32'(last_addr), 32'(v.addr));
            chk({v.name, ".dina"}, last_data, v.data);
        end
        chk({v.name, ".done"}, 32'(done), 32'(v.dn));
        chk({v.name, ".error"}, 32'(error), 32'(v.err));
        chk({v.name, ".cpu_hold"}, 32'(cpu_hold), 32'(v.hold));
        chk({v.name, ".byte_ready"}, 32'(byte_ready), 32'(v.rdy));
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".wea"}, 32'(im_wea), 32'd0);
        chk({name, ".addra"}, 32'(im_addra), 32'd0);
        chk({name, ".dina"}, im_dina, 32'd0);
        chk({name, ".ready"}, 32'(byte_ready), 32'd0);
        chk({name, ".hold"}, 32'(cpu_hold), 32'd0);
        chk({name, ".done"}, 32'(done), 32'd0);
        chk({name, ".error"}, 32'(error), 32'd0);
    endtask

    initial begin
        int base;
        vecs[0] = '{"good", 7, {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1, 11'd0, 32'h12345678, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[1] = '{"zero_len", 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, 11'd0, 32'd0, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[2] = '{"over_len", 2, {8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, 11'd0, 32'd0, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[3] = '{"bad_sum", 7, {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1, 11'd0, 32'h12345678, 1'b0, 4'd2, 1'b1, 1'b0};
        vecs[4] = '{"two_words", 11, {8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                    8'h05, 8'h06, 8'h07, 8'h08, 8'h08, 8'h00},
                    2, 11'd1, 32'h08070605, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[5] = '{"max_len", 2, {8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    0, 11'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b1};

        do_reset();
        chk_idle("reset");

        for (int k = 0; k < 6; k++) run_vec(vecs[k], 1'b1);

        // Timeout: error must appear exactly TIMEOUT edges after the last accepted byte.
        do_reset();
        go();
        send(8'h01);
        repeat (TIMEOUT - 1) tick();
        chk("tmo.before_err", 32'(error), 32'd0);
        chk("tmo.before_ready", 32'(byte_ready), 32'd1);
        tick();
        chk("tmo.err", 32'(error), 32'd3);
        chk("tmo.ready", 32'(byte_ready), 32'd0);
        chk("tmo.hold", 32'(cpu_hold), 32'd1);

        // Reset after two DATA bytes, then a clean load without another reset.
        do_reset();
        base = wr_total;
        go();
        send(8'h01); send(8'h00); send(8'h78); send(8'h56);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("mid_rst");
        tick(); tick();
        chk("mid_rst.writes", 32'(wr_total - base), 32'd0);
        run_vec(vecs[0], 1'b0);

        // start asserted mid-DATA must be ignored.
        do_reset();
        base = wr_total;
        go();
        send(8'h01); send(8'h00); send(8'h78);
        start = 1'b1;
        send(8'h56);
        start = 1'b0;
        send(8'h34); send(8'h12); send(8'h08);
        tick();
        chk("start_ign.writes", 32'(wr_total - base), 32'd1);
        chk("start_ign.dina", last_data, 32'h12345678);
        chk("start_ign.done", 32'(done), 32'd1);

        chk("wea_only_F", 32'(wr_odd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
